// File: rtl/i2c_sample_writer.sv
// rtl/i2c_sample_writer.sv - writes each accepted 8-bit sample to an I2C slave
// as START, {addr,W}, ACK, data, ACK, STOP on open-drain SCL/SDA drives.
module i2c_sample_writer #(
  parameter int unsigned QUARTER_PERIOD_CLOCKS = 125,
  parameter int unsigned QUARTER_COUNTER_BITS  = 8,
  parameter logic [6:0]  DEVICE_ADDRESS        = 7'h48
) (
  input  logic        inputClock,
  input  logic        reset_n,
  input  logic [7:0]  sampleValue,
  input  logic        sampleValid,
  output logic        sampleReady,
  output logic        i2c_sclDriveLow,
  output logic        i2c_sdaDriveLow,
  input  logic        i2c_sdaIn,
  output logic        busy,
  output logic        ackError,
  output logic [15:0] transferCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  localparam logic [QUARTER_COUNTER_BITS-1:0] QUARTER_LAST =
    QUARTER_COUNTER_BITS'(QUARTER_PERIOD_CLOCKS - 1);

  state_t                          state, state_next;
  logic [QUARTER_COUNTER_BITS-1:0] quarter_count;
  logic [1:0]                      phase;
  logic [2:0]                      bit_index;
  logic [7:0]                      shift_byte;
  logic [7:0]                      sample_byte;
  logic                            sda_meta, sda_sync;
  logic                            accept, tick, phase_end, ack_slot;

  assign busy        = (state != S_IDLE);
  assign sampleReady = !busy;
  assign accept      = sampleValid && sampleReady;
  assign tick        = busy && (quarter_count == QUARTER_LAST);
  assign phase_end   = tick && (phase == 2'd3);
  assign ack_slot    = (state == S_ADDR_ACK) || (state == S_DATA_ACK);

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Bus drives are decoded from state/phase so an async reset frees the bus immediately.
  always_comb begin
    state_next      = state;
    i2c_sclDriveLow = 1'b0;
    i2c_sdaDriveLow = 1'b0;
    case (state)
      S_IDLE: if (accept) state_next = S_START;
      S_START: begin
        i2c_sclDriveLow = (phase >= 2'd2);
        i2c_sdaDriveLow = (phase != 2'd0);
        if (phase_end) state_next = S_ADDR;
      end
      S_ADDR, S_DATA: begin
        i2c_sclDriveLow = (phase == 2'd0) || (phase == 2'd3);
        i2c_sdaDriveLow = !shift_byte[7];
        if (phase_end && bit_index == 3'd7)
          state_next = (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
      end
      S_ADDR_ACK: begin
        i2c_sclDriveLow = (phase == 2'd0) || (phase == 2'd3);
        if (phase_end) state_next = ackError ? S_STOP : S_DATA;
      end
      S_DATA_ACK: begin
        i2c_sclDriveLow = (phase == 2'd0) || (phase == 2'd3);
        if (phase_end) state_next = S_STOP;
      end
      S_STOP: begin
        i2c_sclDriveLow = (phase == 2'd0);
        i2c_sdaDriveLow = (phase <= 2'd1);
        if (phase_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      quarter_count <= '0;
      phase         <= 2'd0;
      bit_index     <= 3'd0;
      shift_byte    <= 8'd0;
      sample_byte   <= 8'd0;
      ackError      <= 1'b0;
      transferCount <= 16'd0;
      sda_meta      <= 1'b1;
      sda_sync      <= 1'b1;
    end else begin
      sda_meta <= i2c_sdaIn;
      sda_sync <= sda_meta;
      if (accept) begin
        sample_byte   <= sampleValue;
        shift_byte    <= {DEVICE_ADDRESS, 1'b0};
        ackError      <= 1'b0;
        quarter_count <= '0;
        phase         <= 2'd0;
        bit_index     <= 3'd0;
      end else if (busy) begin
        quarter_count <= tick ? '0 : quarter_count + 1'b1;
        if (tick) phase <= phase + 2'd1;
        // ACK bit is read at the end of the SCL-high half of the slot.
        if (ack_slot && tick && phase == 2'd2 && sda_sync) ackError <= 1'b1;
        if (phase_end) begin
          case (state)
            S_ADDR, S_DATA: begin
              bit_index  <= bit_index + 3'd1;
              shift_byte <= {shift_byte[6:0], 1'b0};
            end
            S_ADDR_ACK: shift_byte <= sample_byte;
            S_STOP:     if (!ackError) transferCount <= transferCount + 16'd1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_sample_writer.sv
// tb/tb_i2c_sample_writer.sv - directed bench with an I2C bus decoder and an ACK/NACK slave model.
module tb_i2c_sample_writer;

  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  sampleValue = 8'd0;
  logic        sampleValid = 1'b0;
  logic        sampleReady;
  logic        scl_low, sda_low;
  logic        busy, ackError;
  logic [15:0] transferCount;
  logic        slave_pull = 1'b0;
  logic        scl_line, sda_line;

  assign scl_line = !scl_low;
  assign sda_line = !(sda_low || slave_pull);

  always #5 clk = ~clk;

  i2c_sample_writer #(
    .QUARTER_PERIOD_CLOCKS(Q),
    .QUARTER_COUNTER_BITS(8),
    .DEVICE_ADDRESS(7'h48)
  ) dut (
    .inputClock(clk),
    .reset_n(reset_n),
    .sampleValue(sampleValue),
    .sampleValid(sampleValid),
    .sampleReady(sampleReady),
    .i2c_sclDriveLow(scl_low),
    .i2c_sdaDriveLow(sda_low),
    .i2c_sdaIn(sda_line),
    .busy(busy),
    .ackError(ackError),
    .transferCount(transferCount)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus decoder + slave: per transaction stats are restarted on every START.
  logic       nack_addr = 1'b0, nack_data = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [8:0] m_shift = 9'd0;
  int         m_bits = 0, m_nbytes = 0, m_toggles = 0;
  logic       m_stop = 1'b0;
  logic [7:0] m_addr = 8'd0, m_data = 8'd0;
  logic       m_ack0 = 1'b1, m_ack1 = 1'b1;
  logic [7:0] data_q[$];

  always @(negedge clk) begin
    logic cur_scl, cur_sda;
    cur_scl = scl_line;
    cur_sda = sda_line;
    if (cur_scl && prev_scl && cur_sda != prev_sda) begin
      if (!cur_sda) begin
        m_toggles = 1; m_bits = 0; m_nbytes = 0; m_stop = 1'b0; slave_pull = 1'b0;
      end else begin
        m_toggles++; m_stop = 1'b1;
      end
    end else if (cur_scl && !prev_scl) begin
      m_shift = {m_shift[7:0], cur_sda};
      m_bits++;
      if (m_bits == 9) begin
        if (m_nbytes == 0) begin
          m_addr = m_shift[8:1]; m_ack0 = m_shift[0];
        end else begin
          m_data = m_shift[8:1]; m_ack1 = m_shift[0]; data_q.push_back(m_shift[8:1]);
        end
        m_nbytes++;
        m_bits = 0;
      end
    end else if (!cur_scl && prev_scl) begin
      if (m_bits == 8) slave_pull = (m_nbytes == 0) ? !nack_addr : !nack_data;
      else             slave_pull = 1'b0;
    end
    prev_scl = cur_scl;
    prev_sda = cur_sda;
  end

  task automatic send(input logic [7:0] v, output int bcyc, output logic err_at_accept);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!sampleReady && guard < 2000) begin @(negedge clk); guard++; end
    sampleValue = v;
    sampleValid = 1'b1;
    @(negedge clk);
    sampleValid = 1'b0;
    err_at_accept = ackError;
    bcyc = 0;
    guard = 0;
    while (busy && guard < 2000) begin bcyc++; @(negedge clk); guard++; end
  endtask

  function automatic logic [7:0] stream_val(int k);
    return 8'(k * 7 + 3);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int   bc;
    logic ea;
    int   n_busy, n_idle;

    // 1 reset
    repeat (3) @(negedge clk);
    check_eq("rst_scl", scl_low, 0);
    check_eq("rst_sda", sda_low, 0);
    check_eq("rst_ready", sampleReady, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", transferCount, 0);
    check_eq("rst_ackerr", ackError, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2 good write
    send(8'hA5, bc, ea);
    check_eq("w1_busy_cycles", bc, 320);
    check_eq("w1_addr", m_addr, 8'h90);
    check_eq("w1_ack0", m_ack0, 0);
    check_eq("w1_nbytes", m_nbytes, 2);
    check_eq("w1_data", m_data, 8'hA5);
    check_eq("w1_ack1", m_ack1, 0);
    check_eq("w1_stop", m_stop, 1);
    check_eq("w1_sda_toggles_scl_high", m_toggles, 2);
    check_eq("w1_count", transferCount, 1);
    check_eq("w1_ackerr", ackError, 0);

    // 3 address NACK
    nack_addr = 1'b1;
    send(8'h3C, bc, ea);
    nack_addr = 1'b0;
    check_eq("nak_a_busy_cycles", bc, 176);
    check_eq("nak_a_nbytes", m_nbytes, 1);
    check_eq("nak_a_addr", m_addr, 8'h90);
    check_eq("nak_a_ack0", m_ack0, 1);
    check_eq("nak_a_stop", m_stop, 1);
    check_eq("nak_a_toggles", m_toggles, 2);
    check_eq("nak_a_ackerr", ackError, 1);
    check_eq("nak_a_count", transferCount, 1);

    // 4 data NACK, then a good write
    nack_data = 1'b1;
    send(8'hC3, bc, ea);
    nack_data = 1'b0;
    check_eq("nak_d_cleared_on_accept", ea, 0);
    check_eq("nak_d_busy_cycles", bc, 320);
    check_eq("nak_d_data", m_data, 8'hC3);
    check_eq("nak_d_ack1", m_ack1, 1);
    check_eq("nak_d_ackerr", ackError, 1);
    check_eq("nak_d_count", transferCount, 1);
    send(8'h11, bc, ea);
    check_eq("w2_cleared_on_accept", ea, 0);
    check_eq("w2_busy_cycles", bc, 320);
    check_eq("w2_data", m_data, 8'h11);
    check_eq("w2_ackerr", ackError, 0);
    check_eq("w2_count", transferCount, 2);

    // 5 continuous valid: accepts at k = 0, 321, 642
    data_q.delete();
    n_busy = 0;
    n_idle = 0;
    @(negedge clk);
    sampleValue = stream_val(0);
    sampleValid = 1'b1;
    for (int k = 1; k <= 963; k++) begin
      @(negedge clk);
      if (k <= 962) begin
        if (busy) n_busy++;
        else      n_idle++;
      end
      sampleValue = stream_val(k);
      if (k == 643) sampleValid = 1'b0;
    end
    sampleValid = 1'b0;
    check_eq("stream_busy_cycles", n_busy, 960);
    check_eq("stream_idle_gaps", n_idle, 2);
    check_eq("stream_nsent", data_q.size(), 3);
    if (data_q.size() == 3) begin
      check_eq("stream_v0", data_q[0], stream_val(0));
      check_eq("stream_v1", data_q[1], stream_val(321));
      check_eq("stream_v2", data_q[2], stream_val(642));
    end
    check_eq("stream_count", transferCount, 5);

    // 6 reset during DATA byte (busy cycle 170: DATA bit 7, SCL high, SDA low)
    @(negedge clk);
    sampleValue = 8'h5A;
    sampleValid = 1'b1;
    @(negedge clk);
    sampleValid = 1'b0;
    repeat (169) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_sda", sda_low, 1);
    check_eq("pre_rst_scl", scl_low, 0);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_scl", scl_low, 0);
    check_eq("mid_rst_sda", sda_low, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_count", transferCount, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h77, bc, ea);
    check_eq("post_rst_busy_cycles", bc, 320);
    check_eq("post_rst_addr", m_addr, 8'h90);
    check_eq("post_rst_data", m_data, 8'h77);
    check_eq("post_rst_toggles", m_toggles, 2);
    check_eq("post_rst_stop", m_stop, 1);
    check_eq("post_rst_count", transferCount, 1);
    check_eq("post_rst_ackerr", ackError, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
